// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: iterative shift-add multiplier and restoring divider.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divides stay iterative.
module muldiv_sequencer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_in,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int unsigned W2 = 2 * XLEN;

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        op_q;
   logic              neg_q;
   logic [XLEN-1:0]   opnd_q;
   logic [W2-1:0]     acc_q;
   logic [XLEN-1:0]   result_q;

   logic              accept;
   logic              is_div_in, sgn_a_op, sgn_b_op, sa_in, sb_in, neg_in;
   logic              div_zero, div_ovf;
   logic [XLEN-1:0]   mag_a, mag_b, special_res;
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [W2-1:0]     mul_d, div_d, step_d, mul_full;
   logic [XLEN-1:0]   div_sel, fin_res;
`ifdef MULDIV_FAST_MUL_EN
   logic [W2-1:0]     fast_a, fast_b, fast_prod;
   logic [XLEN-1:0]   fast_res;
`endif

   // Operand decode: sign handling, magnitudes and the two divide special cases
   always_comb begin
      accept    = (state_q == IDLE) && valid_in && !flush;
      is_div_in = funct3[2];
      sgn_a_op  = is_div_in ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
      sgn_b_op  = is_div_in ? !funct3[0] : (funct3[1:0] == 2'b01);
      sa_in     = sgn_a_op && rs1_data[XLEN-1];
      sb_in     = sgn_b_op && rs2_data[XLEN-1];
      mag_a     = sa_in ? XLEN'(-rs1_data) : rs1_data;
      mag_b     = sb_in ? XLEN'(-rs2_data) : rs2_data;
      neg_in    = (is_div_in && funct3[1]) ? sa_in : (sa_in ^ sb_in);
      div_zero  = is_div_in && (rs2_data == '0);
      div_ovf   = is_div_in && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                  && (rs2_data == '1);
      if (div_zero) special_res = funct3[1] ? rs1_data : '1;
      else          special_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   // One iteration: acc = {hi, lo}; mul keeps the multiplier in lo, div keeps rem:quotient
   always_comb begin
      mul_sum   = {1'b0, acc_q[W2-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_d     = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[W2-1:XLEN], acc_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, opnd_q};
      div_d     = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      step_d    = op_q[2] ? div_d : mul_d;
      mul_full  = neg_q ? W2'(-step_d) : step_d;
      div_sel   = op_q[1] ? step_d[W2-1:XLEN] : step_d[XLEN-1:0];
      if (op_q[2])               fin_res = neg_q ? XLEN'(-div_sel) : div_sel;
      else if (op_q[1:0] == 2'b00) fin_res = mul_full[XLEN-1:0];
      else                       fin_res = mul_full[W2-1:XLEN];
   end

`ifdef MULDIV_FAST_MUL_EN
   always_comb begin
      fast_a    = sgn_a_op ? {{XLEN{rs1_data[XLEN-1]}}, rs1_data} : {{XLEN{1'b0}}, rs1_data};
      fast_b    = sgn_b_op ? {{XLEN{rs2_data[XLEN-1]}}, rs2_data} : {{XLEN{1'b0}}, rs2_data};
      fast_prod = W2'(fast_a * fast_b);
      fast_res  = (funct3[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[W2-1:XLEN];
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         neg_q    <= 1'b0;
         opnd_q   <= '0;
         acc_q    <= '0;
         result_q <= '0;
      end else if (flush) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid_in) begin
                  op_q  <= funct3;
                  neg_q <= neg_in;
                  cnt_q <= '0;
                  if (div_zero || div_ovf) begin
                     result_q <= special_res;
                     state_q  <= FINISH;
`ifdef MULDIV_FAST_MUL_EN
                  end else if (!is_div_in) begin
                     result_q <= fast_res;
                     state_q  <= FINISH;
`endif
                  end else begin
                     opnd_q  <= is_div_in ? mag_b : mag_a;
                     acc_q   <= {{XLEN{1'b0}}, (is_div_in ? mag_a : mag_b)};
                     state_q <= CALC;
                  end
               end
            end
            CALC: begin
               acc_q <= step_d;
               cnt_q <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(XLEN - 1)) begin
                  result_q <= fin_res;
                  state_q  <= FINISH;
               end
            end
            FINISH:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stall  = accept || (state_q == CALC);
   assign busy   = (state_q != IDLE);
   assign done   = (state_q == FINISH) && !flush;
   assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed self-checking bench for muldiv_sequencer (default and MULDIV_FAST_MUL_EN builds).
module tb_muldiv_sequencer;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data;
   logic        flush;
   logic        stall, busy, done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   muldiv_sequencer dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .funct3(funct3),
      .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
      .stall(stall), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Called at a negedge; issues one op and waits for done (bounded).
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat);
      int n, st;
      bit got;
      valid_in = 1'b1; funct3 = f3; rs1_data = a; rs2_data = b;
      #1;
      n = 0; st = 0; got = 0;
      while (!got && n < 100) begin
         if (stall) st++;
         @(posedge clk); n++;
         @(negedge clk);
         if (done) got = 1;
      end
      check({tag, " done_seen"}, 32'(got), 32'd1);
      check({tag, " latency"}, 32'(n), 32'(lat));
      check({tag, " stall_cycles"}, 32'(st), 32'(lat));
      check({tag, " stall_at_done"}, 32'(stall), 32'd0);
      check({tag, " result"}, result, exp);
      valid_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; funct3 = '0; rs1_data = '0; rs2_data = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      check("rst busy", 32'(busy), 32'd0);
      check("rst stall", 32'(stall), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      run_op("MUL 7*6",        3'b000, 32'd7,        32'd6,        32'd42,       MUL_LAT); @(negedge clk);
      run_op("MUL -3*5",       3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, MUL_LAT); @(negedge clk);
      run_op("MULH min*min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT); @(negedge clk);
      run_op("MULHU",          3'b011, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT); @(negedge clk);
      run_op("MULHSU -1*2",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, MUL_LAT); @(negedge clk);
      run_op("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT); @(negedge clk);
      run_op("REM -7%2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT); @(negedge clk);
      run_op("DIV 7/-2",       3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, DIV_LAT); @(negedge clk);
      run_op("REM 7%-2",       3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        DIV_LAT); @(negedge clk);
      run_op("DIVU 100/7",     3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT); @(negedge clk);
      run_op("DIVU by zero",   3'b101, 32'd55,       32'd0,        32'hFFFFFFFF, 1);       @(negedge clk);
      run_op("REM by zero",    3'b110, 32'h1234,     32'd0,        32'h1234,     1);       @(negedge clk);
      run_op("DIV overflow",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);       @(negedge clk);
      run_op("REM overflow",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);       @(negedge clk);
      run_op("REMU 100%7",     3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT); @(negedge clk);

      // Flush in the middle of a DIV: abort, no done, result keeps 2
      valid_in = 1'b1; funct3 = 3'b100; rs1_data = 32'd1000; rs2_data = 32'd3;
      repeat (10) @(negedge clk);
      valid_in = 1'b0; flush = 1'b1;
      #1;
      check("flush done suppressed", 32'(done), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush busy", 32'(busy), 32'd0);
      check("flush stall", 32'(stall), 32'd0);
      check("flush done", 32'(done), 32'd0);
      check("flush result kept", result, 32'd2);
      run_op("DIV after flush", 3'b100, 32'd1000, 32'd3, 32'd333, DIV_LAT); @(negedge clk);

      // Synchronous reset mid-CALC
      valid_in = 1'b1; funct3 = 3'b101; rs1_data = 32'd99; rs2_data = 32'd4;
      repeat (5) @(negedge clk);
      check("pre-rst busy", 32'(busy), 32'd1);
      valid_in = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("mid rst busy", 32'(busy), 32'd0);
      check("mid rst stall", 32'(stall), 32'd0);
      check("mid rst done", 32'(done), 32'd0);
      check("mid rst result", result, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back MUL then DIVU: valid re-asserted the cycle after done
      run_op("b2b MUL", 3'b000, 32'd12, 32'd11, 32'd132, MUL_LAT); @(negedge clk);
      run_op("b2b DIVU", 3'b101, 32'd50, 32'd8, 32'd6, DIV_LAT);
      begin
         int extra = 0;
         repeat (40) begin
            @(negedge clk);
            if (done || busy) extra++;
         end
         check("b2b no duplicate", 32'(extra), 32'd0);
         check("b2b result stable", result, 32'd6);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
